ldst_agu: RTL and testbench
===========================

Name: ldst_agu

Overview:
- Strided address-generation sequencer. Sits directly downstream of the load/store unit.
- Pops one access descriptor (base, length, stride) per request and returns a one-cycle access grant.
- Walks `length` element addresses `base + i*stride` onto the data-memory port, then pulses end-of-access back upstream.
- Also drives the per-element ready that upstream registers and uses for its stall.

Parameters:
- LIMIT_ADDR, '1 (all ones of address_t), highest legal element address; used only with AGU_BOUND_CHECK_EN.
- IDLE_GAP, 0, extra idle cycles inserted after TERM before a new request is accepted (0..3).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- I_Stall  in  1  global stall; freezes all state
- I_Req  in  1  descriptor valid from load/store unit
- I_Length  in  address_t  element count
- I_Stride  in  stride_t  signed element stride
- I_Base  in  address_t  start address
- O_Access_Grant  out  1  one-cycle pulse: descriptor accepted
- O_Term  out  1  one-cycle pulse: last element done
- O_Ready  out  1  element transferred this cycle
- O_Mem_Req  out  1  memory address valid
- O_Mem_Addr  out  address_t  element address
- I_Mem_Ack  in  1  memory accepted O_Mem_Addr this cycle
- O_Busy  out  1  state != IDLE
- O_Error  out  1  bound violation, sticky until next grant (0 when macro is off)

Behaviour:
- Reset: state=IDLE, gap counter=0. All outputs 0, including O_Mem_Addr. Reset mid-access aborts with no O_Term.
- States IDLE, RUN, TERM, GAP. No transitions or register updates in any state while I_Stall=1.
- IDLE + I_Req:
  - Latch Base into the address register.
  - Latch Length into the remaining-count register.
  - Latch Stride, sign-extended to address_t.
  - Assert O_Access_Grant in the same cycle (combinational on I_Req & ~I_Stall in IDLE).
  - Next state: RUN if Length != 0, else TERM.
- RUN:
  - O_Mem_Req=1; O_Mem_Addr = address register.
  - On I_Mem_Ack:
    - O_Ready=1 that cycle.
    - address += stride, modulo 2^width (wrap-around, no saturation).
    - remaining -= 1.
    - If remaining was 1, go to TERM.
  - Without ack, hold address and state.
- TERM:
  - O_Term=1 for exactly one cycle. O_Mem_Req=0.
  - Next state GAP if IDLE_GAP>0, else IDLE.
- GAP: count IDLE_GAP cycles, then go to IDLE. I_Req is ignored in TERM and GAP.
- Latency:
  - Grant to first O_Mem_Req: 1 cycle.
  - N elements with ack held high: N cycles in RUN, O_Term on cycle N+1 after grant.
  - Earliest next grant: IDLE_GAP+1 cycles after O_Term.
- Length=0: grant, then O_Term next cycle; no memory request is issued.
- I_Mem_Ack outside RUN is ignored. I_Req during stall is not granted.
- Descriptor inputs are sampled only at grant; later changes have no effect.

Optional Feature:
- Macro AGU_BOUND_CHECK_EN.
- When defined:
  - In RUN, if the address register > LIMIT_ADDR, O_Mem_Req is suppressed.
  - O_Error is set and the state goes directly to TERM; O_Term still pulses.
  - O_Error clears on the next O_Access_Grant.
- When undefined: no comparator; O_Error tied 0; LIMIT_ADDR unused.

Decomposition:
- pkg_tpu additions:
  - agu_state_t enum {IDLE, RUN, TERM, GAP}.
  - Constant AGU_GAP_MAX=3.
- Reuse existing address_t and stride_t.
- One natural sub-module: agu_stride_counter, holding the address accumulator and remaining counter with load/step/hold controls.
- FSM stays in ldst_agu.

Test Plan:
- Base=0x100, Stride=4, Length=3, ack always 1 -> grant at t0; addrs 0x100, 0x104, 0x108 at t1–t3; O_Ready t1–t3; O_Term t4.
- Base=0x10, Stride=-2, Length=4 -> addrs 0x10, 0x0E, 0x0C, 0x0A. Base=0x0, Stride=-1, Length=2 -> 0x0, then all-ones (wrap).
- Length=0 -> grant t0, O_Term t1, O_Mem_Req never 1.
- Length=2 with ack low t1–t2 and I_Stall=1 at t4 -> addr held at base until ack; no progress during stall; O_Term delayed accordingly; grants for back-to-back requests spaced by IDLE_GAP+1 cycles after O_Term.
- Reset asserted mid-RUN (after 1 of 4 elements) -> next cycle all outputs 0, no O_Term; fresh request granted normally.
- AGU_BOUND_CHECK_EN, LIMIT_ADDR=0x108, Base=0x100, Stride=8, Length=4 -> addrs 0x100, 0x108; then no request, O_Error=1, O_Term pulse; O_Error clears on next grant.

Source files
------------

// File: rtl/pkg_tpu.sv
// Shared TPU types, plus the state encoding and limits for the strided load/store address generator.
package pkg_tpu;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned STRIDE_W = 16;

    typedef logic [ADDR_W-1:0]          address_t;
    typedef logic signed [STRIDE_W-1:0] stride_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TERM = 2'd2,
        GAP  = 2'd3
    } agu_state_t;

    localparam int unsigned AGU_GAP_MAX = 3;
    localparam int unsigned GAP_CNT_W   = 2;

    // Sign-extend a signed element stride to address width so that address + stride wraps modulo 2^ADDR_W.
    function automatic address_t sext_stride(input stride_t s);
        return {{(ADDR_W-STRIDE_W){s[STRIDE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/ldst_agu_stride_counter.sv
// Address accumulator and remaining-element counter for the strided AGU.
// load takes priority over step. When neither is asserted, the counter holds its value.
module agu_stride_counter
    import pkg_tpu::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     load,
    input  logic     step,
    input  address_t load_base,
    input  address_t load_length,
    input  address_t load_stride,
    output address_t addr,
    output address_t remaining
);

    address_t stride_q;

    // Latch the descriptor on load; advance one element on step.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            stride_q  <= '0;
        end else if (load) begin
            addr      <= load_base;
            remaining <= load_length;
            stride_q  <= load_stride;
        end else if (step) begin
            addr      <= addr + stride_q;
            remaining <= remaining - ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ldst_agu.sv
// Strided address-generation sequencer downstream of the load/store unit.
// Optional bound checking is enabled with the macro AGU_BOUND_CHECK_EN.
module ldst_agu
    import pkg_tpu::*;
#(
    parameter address_t    LIMIT_ADDR = '1,
    parameter int unsigned IDLE_GAP   = 0
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     I_Stall,
    input  logic     I_Req,
    input  address_t I_Length,
    input  stride_t  I_Stride,
    input  address_t I_Base,
    output logic     O_Access_Grant,
    output logic     O_Term,
    output logic     O_Ready,
    output logic     O_Mem_Req,
    output address_t O_Mem_Addr,
    input  logic     I_Mem_Ack,
    output logic     O_Busy,
    output logic     O_Error
);

    if (IDLE_GAP > AGU_GAP_MAX) begin : g_bad_gap
        $error("IDLE_GAP out of range");
    end

    agu_state_t             state, state_next;
    logic [GAP_CNT_W-1:0]   gap_cnt, gap_next;
    logic                   load, step, err_set;
    logic                   out_of_bound;
    address_t               addr, remaining;

    agu_stride_counter u_counter (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .load_base   (I_Base),
        .load_length (I_Length),
        .load_stride (sext_stride(I_Stride)),
        .addr        (addr),
        .remaining   (remaining)
    );

`ifdef AGU_BOUND_CHECK_EN
    logic error_q;

    assign out_of_bound = (addr > LIMIT_ADDR);

    // Sticky bound-violation flag, cleared by the next accepted descriptor.
    always_ff @(posedge clock) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (load) begin
            error_q <= 1'b0;
        end else if (err_set) begin
            error_q <= 1'b1;
        end
    end

    assign O_Error = error_q;
`else
    logic unused_limit;

    assign unused_limit = ^{LIMIT_ADDR, err_set};
    assign out_of_bound = 1'b0;
    assign O_Error      = 1'b0;
`endif

    // State register and idle-gap counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
        end
    end

    // Next-state and per-cycle handshake outputs. A stall freezes everything and masks all pulses.
    always_comb begin
        state_next     = state;
        gap_next       = gap_cnt;
        load           = 1'b0;
        step           = 1'b0;
        err_set        = 1'b0;
        O_Access_Grant = 1'b0;
        O_Mem_Req      = 1'b0;
        O_Ready        = 1'b0;
        O_Term         = 1'b0;
        case (state)
            IDLE: begin
                if (I_Req && !I_Stall && !reset) begin
                    O_Access_Grant = 1'b1;
                    load           = 1'b1;
                    state_next     = (I_Length != '0) ? RUN : TERM;
                end
            end
            RUN: begin
                if (!I_Stall) begin
                    if (out_of_bound) begin
                        err_set    = 1'b1;
                        state_next = TERM;
                    end else begin
                        O_Mem_Req = 1'b1;
                        if (I_Mem_Ack) begin
                            O_Ready = 1'b1;
                            step    = 1'b1;
                            if (remaining == ADDR_W'(1)) begin
                                state_next = TERM;
                            end
                        end
                    end
                end
            end
            TERM: begin
                if (!I_Stall) begin
                    O_Term = 1'b1;
                    if (IDLE_GAP > 0) begin
                        state_next = GAP;
                        gap_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (!I_Stall) begin
                    if (gap_cnt == GAP_CNT_W'(IDLE_GAP - 1)) begin
                        state_next = IDLE;
                    end else begin
                        gap_next = gap_cnt + GAP_CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign O_Mem_Addr = addr;
    assign O_Busy     = (state != IDLE);

endmodule

// File: tb/tb_ldst_agu.sv
// Directed self-checking bench for ldst_agu, built with IDLE_GAP=1.
module tb_ldst_agu;
    import pkg_tpu::*;

    logic     clock = 1'b0;
    logic     reset;
    logic     I_Stall, I_Req, I_Mem_Ack;
    address_t I_Length, I_Base;
    stride_t  I_Stride;
    logic     O_Access_Grant, O_Term, O_Ready, O_Mem_Req, O_Busy, O_Error;
    address_t O_Mem_Addr;

    int n_vec = 0;
    int n_err = 0;

`ifdef AGU_BOUND_CHECK_EN
    localparam address_t TB_LIMIT = 32'h0000_0108;
`else
    localparam address_t TB_LIMIT = '1;
`endif

    ldst_agu #(.LIMIT_ADDR(TB_LIMIT), .IDLE_GAP(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .I_Stall        (I_Stall),
        .I_Req          (I_Req),
        .I_Length       (I_Length),
        .I_Stride       (I_Stride),
        .I_Base         (I_Base),
        .O_Access_Grant (O_Access_Grant),
        .O_Term         (O_Term),
        .O_Ready        (O_Ready),
        .O_Mem_Req      (O_Mem_Req),
        .O_Mem_Addr     (O_Mem_Addr),
        .I_Mem_Ack      (I_Mem_Ack),
        .O_Busy         (O_Busy),
        .O_Error        (O_Error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one descriptor with ack held high and check the whole sequence through the idle gap.
    task automatic burst(input string nm, input address_t base, input stride_t stride, input address_t len,
                         input address_t e0, input address_t e1, input address_t e2, input address_t e3);
        address_t e [4];
        e = '{e0, e1, e2, e3};
        I_Req = 1'b1; I_Base = base; I_Stride = stride; I_Length = len; I_Mem_Ack = 1'b1;
        #1;
        check({nm, " grant"}, 32'(O_Access_Grant), 32'd1);
        check({nm, " req@grant"}, 32'(O_Mem_Req), 32'd0);
        tick();
        I_Req = 1'b0; I_Base = 32'hDEAD_BEE0; I_Stride = 16'sh0007; I_Length = 32'd9;
        for (int i = 0; i < int'(len); i++) begin
            #1;
            check({nm, " req"},   32'(O_Mem_Req), 32'd1);
            check({nm, " addr"},  O_Mem_Addr,     e[i]);
            check({nm, " ready"}, 32'(O_Ready),   32'd1);
            check({nm, " term"},  32'(O_Term),    32'd0);
            tick();
        end
        #1;
        check({nm, " term pulse"}, 32'(O_Term),    32'd1);
        check({nm, " req@term"},   32'(O_Mem_Req), 32'd0);
        check({nm, " error"},      32'(O_Error),   32'd0);
        tick();
        I_Req = 1'b1;
        #1;
        check({nm, " gap term"},  32'(O_Term),         32'd0);
        check({nm, " gap busy"},  32'(O_Busy),         32'd1);
        check({nm, " gap grant"}, 32'(O_Access_Grant), 32'd0);
        I_Req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; I_Stall = 1'b0; I_Req = 1'b0; I_Mem_Ack = 1'b0;
        I_Length = '0; I_Base = '0; I_Stride = '0;
        tick();
        I_Req = 1'b1; I_Base = 32'h55; I_Length = 32'd2;
        tick();
        #1;
        check("reset grant", 32'(O_Access_Grant), 32'd0);
        check("reset busy",  32'(O_Busy),         32'd0);
        check("reset addr",  O_Mem_Addr,          32'd0);
        check("reset req",   32'(O_Mem_Req),      32'd0);
        check("reset term",  32'(O_Term),         32'd0);
        check("reset error", 32'(O_Error),        32'd0);
        reset = 1'b0; I_Req = 1'b0;
        tick();

        // A request during stall is not granted.
        I_Stall = 1'b1; I_Req = 1'b1; I_Base = 32'h100; I_Stride = 16'sd4; I_Length = 32'd3;
        #1;
        check("stall grant", 32'(O_Access_Grant), 32'd0);
        tick();
        #1;
        check("stall busy", 32'(O_Busy), 32'd0);
        I_Stall = 1'b0;

        burst("inc4", 32'h100, 16'sd4, 32'd3, 32'h100, 32'h104, 32'h108, 32'h0);
        burst("len0", 32'h40, 16'sd4, 32'd0, 32'h0, 32'h0, 32'h0, 32'h0);

`ifdef AGU_BOUND_CHECK_EN
        // Third element 0x110 exceeds the limit of 0x108.
        I_Req = 1'b1; I_Base = 32'h100; I_Stride = 16'sd8; I_Length = 32'd4; I_Mem_Ack = 1'b1;
        #1;
        check("bnd grant", 32'(O_Access_Grant), 32'd1);
        tick();
        I_Req = 1'b0;
        #1;
        check("bnd addr0", O_Mem_Addr, 32'h100);
        tick();
        #1;
        check("bnd addr1", O_Mem_Addr, 32'h108);
        check("bnd req1",  32'(O_Mem_Req), 32'd1);
        tick();
        #1;
        check("bnd suppressed", 32'(O_Mem_Req), 32'd0);
        check("bnd no ready",   32'(O_Ready),   32'd0);
        tick();
        #1;
        check("bnd term",  32'(O_Term),  32'd1);
        check("bnd error", 32'(O_Error), 32'd1);
        tick();
        tick();
        I_Req = 1'b1; I_Base = 32'h0; I_Stride = 16'sd4; I_Length = 32'd1;
        #1;
        check("bnd regrant", 32'(O_Access_Grant), 32'd1);
        check("bnd err held", 32'(O_Error), 32'd1);
        tick();
        I_Req = 1'b0;
        #1;
        check("bnd err clear", 32'(O_Error), 32'd0);
        tick();
        tick();
        tick();
`else
        burst("dec2", 32'h10, -16'sd2, 32'd4, 32'h10, 32'h0E, 32'h0C, 32'h0A);
        burst("wrap", 32'h0, -16'sd1, 32'd2, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);

        // Ack withheld two cycles, then a stall in the middle of the access.
        I_Req = 1'b1; I_Base = 32'h200; I_Stride = 16'sh10; I_Length = 32'd2; I_Mem_Ack = 1'b0;
        #1;
        check("hold grant", 32'(O_Access_Grant), 32'd1);
        tick();
        I_Req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("hold req",   32'(O_Mem_Req), 32'd1);
            check("hold addr",  O_Mem_Addr,     32'h200);
            check("hold ready", 32'(O_Ready),   32'd0);
            tick();
        end
        I_Mem_Ack = 1'b1;
        #1;
        check("hold ack0 ready", 32'(O_Ready), 32'd1);
        check("hold ack0 addr",  O_Mem_Addr,   32'h200);
        tick();
        I_Stall = 1'b1;
        #1;
        check("stall ready", 32'(O_Ready), 32'd0);
        check("stall addr",  O_Mem_Addr,   32'h210);
        tick();
        I_Stall = 1'b0;
        #1;
        check("post stall ready", 32'(O_Ready), 32'd1);
        check("post stall addr",  O_Mem_Addr,   32'h210);
        check("post stall term",  32'(O_Term),  32'd0);
        tick();
        #1;
        check("hold term", 32'(O_Term), 32'd1);
        tick();
        tick();

        // Reset after one of four elements aborts the access with no term pulse.
        I_Req = 1'b1; I_Base = 32'h300; I_Stride = 16'sd1; I_Length = 32'd4; I_Mem_Ack = 1'b1;
        tick();
        I_Req = 1'b0;
        #1;
        check("abort addr0", O_Mem_Addr, 32'h300);
        tick();
        reset = 1'b1;
        tick();
        #1;
        check("abort busy", 32'(O_Busy),    32'd0);
        check("abort addr", O_Mem_Addr,     32'd0);
        check("abort req",  32'(O_Mem_Req), 32'd0);
        check("abort term", 32'(O_Term),    32'd0);
        reset = 1'b0;
        tick();
        #1;
        check("abort no term", 32'(O_Term), 32'd0);
        burst("fresh", 32'h400, 16'sd8, 32'd2, 32'h400, 32'h408, 32'h0, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
